// File: rtl/change_dispenser.sv
// change_dispenser: coin-return engine with an inactivity timeout and a
// per-denomination coin stock; dispenses the balance greedily, one coin
// per cycle, largest denomination first.
//
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   i_input_coin       coin-inserted strobes (activity)
//   i_select_item      item-select strobes (activity)
//   i_trigger_return   explicit return request
//   i_balance          current customer balance
//   i_refill_coin      per-coin refill strobes (+1 stock each)
//   o_return_coin      one-hot coin being returned this cycle
//   o_return_value     value of the coin on o_return_coin, else 0
//   o_wait_time        remaining inactivity count
//   o_busy             high while loading / dispensing
//   o_done             one-cycle pulse at the end of a return
//   o_shortfall        amount left unreturned by the last return
//   o_stock            per-coin stock counters, packed like COIN_VALUES
module change_dispenser #(
   parameter int NUM_COINS  = 3,
   parameter int NUM_ITEMS  = 4,
   parameter int TOTAL_BITS = 31,
   parameter logic [NUM_COINS*TOTAL_BITS-1:0] COIN_VALUES =
      {TOTAL_BITS'(1000), TOTAL_BITS'(500), TOTAL_BITS'(100)},
   parameter int WAIT_TIME  = 100,
   parameter int STOCK_BITS = 8,
   parameter int STOCK_INIT = 8
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [NUM_COINS-1:0]            i_input_coin,
   input  logic [NUM_ITEMS-1:0]            i_select_item,
   input  logic                            i_trigger_return,
   input  logic [TOTAL_BITS-1:0]           i_balance,
   input  logic [NUM_COINS-1:0]            i_refill_coin,
   output logic [NUM_COINS-1:0]            o_return_coin,
   output logic [TOTAL_BITS-1:0]           o_return_value,
   output logic [31:0]                     o_wait_time,
   output logic                            o_busy,
   output logic                            o_done,
   output logic [TOTAL_BITS-1:0]           o_shortfall,
   output logic [NUM_COINS*STOCK_BITS-1:0] o_stock
);

   localparam logic [31:0] WAIT_V = 32'(WAIT_TIME);

   localparam logic [STOCK_BITS-1:0] STOCK_INIT_V =
      STOCK_BITS'(STOCK_INIT);
   localparam logic [STOCK_BITS-1:0] STOCK_ONE = STOCK_BITS'(1);
   localparam logic [STOCK_BITS-1:0] STOCK_MAX = '1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DISPENSE,
      DONE
   } state_t;

   state_t state_q;
   state_t state_d;

   logic                  armed_q;
   logic                  armed_d;
   logic [TOTAL_BITS-1:0] remaining_q;
   logic [TOTAL_BITS-1:0] remaining_d;

   logic [31:0]           wait_d;
   logic [NUM_COINS-1:0]  coin_d;
   logic [TOTAL_BITS-1:0] value_d;
   logic                  busy_d;
   logic                  done_d;
   logic [TOTAL_BITS-1:0] shortfall_d;

   logic [NUM_COINS-1:0][STOCK_BITS-1:0] stock_q;
   logic [NUM_COINS-1:0][STOCK_BITS-1:0] stock_d;

   logic [NUM_COINS-1:0]  pick_oh;
   logic [TOTAL_BITS-1:0] pick_val;
   logic                  pick_found;
   logic                  dispense;
   logic                  activity;
   logic                  timeout;

   assign activity = (|i_input_coin) || (|i_select_item);

   // Fires once per activity period: armed is cleared on entering LOAD.
   assign timeout = armed_q
                 && (o_wait_time == '0)
                 && (i_balance != '0);

   // Greedy pick: later (higher-valued) candidates override earlier ones.
   always_comb begin
      pick_oh  = '0;
      pick_val = '0;
      for (int i = 0; i < NUM_COINS; i++) begin
         if ((stock_q[i] != '0) &&
             (COIN_VALUES[i*TOTAL_BITS +: TOTAL_BITS] <= remaining_q)) begin
            pick_oh    = '0;
            pick_oh[i] = 1'b1;
            pick_val   = COIN_VALUES[i*TOTAL_BITS +: TOTAL_BITS];
         end
      end
   end

   assign pick_found = |pick_oh;

   assign dispense = (state_q == DISPENSE)
                  && pick_found
                  && (remaining_q != '0);

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (i_trigger_return || timeout) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            state_d = DISPENSE;
         end
         DISPENSE: begin
            if (!dispense) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output / datapath next values
   always_comb begin
      armed_d     = armed_q;
      remaining_d = remaining_q;
      wait_d      = WAIT_V;
      coin_d      = '0;
      value_d     = '0;
      busy_d      = (state_d == LOAD) || (state_d == DISPENSE);
      done_d      = 1'b0;
      shortfall_d = o_shortfall;
      unique case (state_q)
         IDLE: begin
            if (state_d == LOAD) begin
               armed_d = 1'b0;
            end else if (activity) begin
               armed_d = 1'b1;
            end
            if ((state_d == LOAD) || activity) begin
               wait_d = WAIT_V;
            end else if (o_wait_time != '0) begin
               wait_d = o_wait_time - 32'd1;
            end else begin
               wait_d = '0;
            end
         end
         LOAD: begin
            remaining_d = i_balance;
         end
         DISPENSE: begin
            if (dispense) begin
               coin_d      = pick_oh;
               value_d     = pick_val;
               remaining_d = remaining_q - pick_val;
            end else begin
               done_d      = 1'b1;
               shortfall_d = remaining_q;
            end
         end
         DONE: begin
            wait_d = WAIT_V;
         end
         default: begin
            wait_d = WAIT_V;
         end
      endcase
   end

   // Stock: refill and dispense of the same coin cancel out.
   always_comb begin
      for (int i = 0; i < NUM_COINS; i++) begin
         stock_d[i] = stock_q[i];
         if (i_refill_coin[i] && !coin_d[i]) begin
            if (stock_q[i] != STOCK_MAX) begin
               stock_d[i] = stock_q[i] + STOCK_ONE;
            end
         end else if (!i_refill_coin[i] && coin_d[i]) begin
            stock_d[i] = stock_q[i] - STOCK_ONE;
         end
      end
   end

   // Output and datapath registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         armed_q        <= 1'b0;
         remaining_q    <= '0;
         o_return_coin  <= '0;
         o_return_value <= '0;
         o_wait_time    <= WAIT_V;
         o_busy         <= 1'b0;
         o_done         <= 1'b0;
         o_shortfall    <= '0;
         stock_q        <= {NUM_COINS{STOCK_INIT_V}};
      end else begin
         armed_q        <= armed_d;
         remaining_q    <= remaining_d;
         o_return_coin  <= coin_d;
         o_return_value <= value_d;
         o_wait_time    <= wait_d;
         o_busy         <= busy_d;
         o_done         <= done_d;
         o_shortfall    <= shortfall_d;
         stock_q        <= stock_d;
      end
   end

   assign o_stock = stock_q;

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Parametrised coin-return engine for the vending machine. It keeps the inactivity timeout and tracks a per-denomination coin stock. On timeout or an explicit return request it dispenses the pending balance greedily, one coin per cycle, largest denomination first. It sits between the balance bookkeeping, which supplies the current balance and accumulates `o_return_value`, and the coin-output hardware.

## Interface
- `NUM_COINS`, 3: number of denominations; index 0 is the smallest value.
- `NUM_ITEMS`, 4: width of the item-select bus.
- `TOTAL_BITS`, 31: width of all money quantities.
- `COIN_VALUES`, {1000,500,100}: packed `NUM_COINS*TOTAL_BITS`; slice i is the value of coin i, strictly increasing with i.
- `WAIT_TIME`, 100: inactivity timeout in cycles.
- `STOCK_BITS`, 8: width of each stock counter.
- `STOCK_INIT`, 8: stock of every denomination after reset.
- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `i_input_coin`, in, NUM_COINS: coin-inserted strobes, one cycle per coin.
- `i_select_item`, in, NUM_ITEMS: item-select strobes.
- `i_trigger_return`, in, 1: return request.
- `i_balance`, in, TOTAL_BITS: current customer balance (input − output − returned).
- `i_refill_coin`, in, NUM_COINS: each set bit adds one coin to that stock.
- `o_return_coin`, out, NUM_COINS: one-hot, at most one coin per cycle.
- `o_return_value`, out, TOTAL_BITS: value of the coin on `o_return_coin`; 0 when no coin.
- `o_wait_time`, out, 32: remaining timeout count.
- `o_busy`, out, 1: high in LOAD and DISPENSE.
- `o_done`, out, 1: one-cycle pulse when a return sequence ends.
- `o_shortfall`, out, TOTAL_BITS: amount left unreturned by the last sequence.
- `o_stock`, out, NUM_COINS*STOCK_BITS: per-coin stock counts, packed like `COIN_VALUES`.

## Operation
- FSM states: IDLE, LOAD, DISPENSE, DONE.
- IDLE:
  - Any nonzero `i_input_coin` or `i_select_item` reloads `o_wait_time` to WAIT_TIME and sets the internal `armed` flag.
  - Otherwise `o_wait_time` decrements, saturating at 0.
  - Go to LOAD if `i_trigger_return` is high, or if `armed` and `o_wait_time`==0 and `i_balance`!=0.
  - Entering LOAD clears `armed`. Each period of activity therefore fires the timeout at most once.
- LOAD: latch `remaining` = `i_balance`, then go to DISPENSE.
- DISPENSE, evaluated each cycle:
  - Pick the highest i with stock[i]>0 and COIN_VALUES[i] ≤ `remaining`.
  - If such an i exists: pulse `o_return_coin[i]`, drive `o_return_value` with its value, decrement stock[i], and subtract the value from `remaining`.
  - If none exists, or `remaining`==0: go to DONE.
- DONE:
  - `o_done`=1 for this cycle only.
  - `o_shortfall` = `remaining`, held until the next DONE.
  - Reload `o_wait_time` to WAIT_TIME, then go to IDLE.
- While busy (LOAD or DISPENSE), `i_input_coin`, `i_select_item` and `i_trigger_return` are ignored, and `o_wait_time` holds at WAIT_TIME. Upstream blocks coin insertion while `o_busy` is high.
- Stock rules:
  - Refill and dispense of the same coin in the same cycle leave the stock unchanged.
  - Refill saturates at 2^STOCK_BITS−1.
  - Refill is accepted in every state.
- A trigger with `i_balance`==0 runs LOAD→DISPENSE→DONE with no coins and `o_shortfall`=0.
- All arithmetic is unsigned at TOTAL_BITS. `remaining` never underflows because of the ≤ check.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE, `armed` 0.
  - `o_return_coin` 0, `o_return_value` 0.
  - `o_wait_time` WAIT_TIME.
  - `o_busy` 0, `o_done` 0, `o_shortfall` 0.
  - Every stock = STOCK_INIT.
- Reset mid-sequence aborts at the next edge. Coins already issued are not recalled.
- Sequence timing, for a trigger sampled at edge k with n coins returned:
  - State is LOAD after edge k.
  - `remaining` is latched at edge k+1.
  - The coins appear after edges k+2 … k+1+n, in consecutive cycles with no gaps.
  - `o_done` is high after edge k+2+n.
  - State is IDLE after edge k+3+n.
- Timeout:
  - The last activity at edge j reloads the counter.
  - The counter reaches 0 after edge j+WAIT_TIME.
  - LOAD follows at the next edge.

## Test plan
- Default params, balance 1700, trigger → coins 1000, 500, 100, 100 on 4 consecutive cycles; `o_done` one cycle later; `o_shortfall`=0; stocks become 7, 7, 6.
- Stock of coin 2 forced to 0 via parameter STOCK_INIT test variant or prior drain; balance 1000 → 500, 500.
- Balance 150 → one coin of 100, then `o_done` with `o_shortfall`=50.
- Timeout:
  - WAIT_TIME=5, insert coin 1 with balance 500, then idle → dispense starts 5+1 cycles after the insert.
  - With no further activity, no second timeout occurs.
- Reset_n low during the second coin of a 4-coin return → next cycle: all outputs at reset values, stocks back at STOCK_INIT.
- `i_refill_coin[0]` pulsed in the same cycle as a 100-coin dispense → stock[0] unchanged. Refill at 255 with STOCK_BITS=8 → stays 255.
